// File: rtl/uart_rx_if.sv
// Byte pop interface between the UART receiver FIFO and the core-side consumer.
// The receiver drives data/valid (master); the consumer drives ready (slave).
interface uart_rx_if;
  logic [7:0] RDATA;
  logic       RVALID;
  logic       RREADY;

  modport master (output RDATA, output RVALID, input RREADY);
  modport slave  (input RDATA, input RVALID, output RREADY);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// first-word-fall-through receive FIFO and sticky framing/overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           CLK,
  input  logic           NRST,
  input  logic           RX_DSER,
  uart_rx_if.master      bus,
  output logic           FERR,
  output logic           OVERRUN,
  input  logic           CLR_ERR
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   C_DEPTH = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  logic [1:0]    r_sync;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_rd_ptr;
  logic          r_ferr;
  logic          r_ovr;

  logic          w_rx;
  logic          w_stop_smp;
  logic          w_push;
  logic          w_ferr_set;
  logic [PW:0]   w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_ovr_set;

  assign w_rx       = r_sync[1];
  assign w_stop_smp = (r_state == S_STOP) && (r_cnt == C_LAST);
  assign w_push     = w_stop_smp && w_rx;
  assign w_ferr_set = w_stop_smp && !w_rx;
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (w_count == C_DEPTH);
  assign w_pop      = !w_empty && bus.RREADY;
  // A full FIFO still takes the byte when the head is popped in the same cycle.
  assign w_wr_en    = w_push && (!w_full || w_pop);
  assign w_ovr_set  = w_push && w_full && !w_pop;

  assign bus.RDATA  = r_mem[r_rd_ptr[PW-1:0]];
  assign bus.RVALID = !w_empty;
  assign FERR       = r_ferr;
  assign OVERRUN    = r_ovr;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], RX_DSER};
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            if (w_rx) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= '0;
              r_bit   <= 3'd0;
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_shift[r_bit] <= w_rx;
            r_cnt          <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            // A low stop bit may be a break; hold off until the line returns high.
            r_state <= w_rx ? S_IDLE : S_WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (w_rx) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[PW-1:0]] <= r_shift;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (CLR_ERR) begin
        r_ferr <= 1'b0;
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (CLR_ERR) begin
        r_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic clk;
  logic nrst;
  logic rx;
  logic ferr;
  logic overrun;
  logic clr_err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .CLK     (clk),
    .NRST    (nrst),
    .RX_DSER (rx),
    .bus     (bus),
    .FERR    (ferr),
    .OVERRUN (overrun),
    .CLR_ERR (clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int j);
    if (j == 0) return 1'b0;
    else if (j <= 8) return d[j-1];
    else return stop;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop);
    for (int k = 0; k < FRAME; k++) begin
      if (k % CPB == 0) rx = frame_bit(d, stop, k / CPB);
      @(negedge clk);
    end
  endtask

  task automatic pop_byte(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    for (int i = 0; i < 50; i++) begin
      if (bus.RVALID === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      d = bus.RDATA;
      bus.RREADY = 1'b1;
      @(negedge clk);
      bus.RREADY = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.RDATA, bus.RVALID, ferr, overrun} !== 11'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {bus.RDATA, bus.RVALID, ferr, overrun});
    end
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.RVALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_rvalid got=%b exp=0", bus.RVALID);
    end
  endtask

  task automatic test_nominal();
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    checks++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== exp_q[0]) begin
      failures++;
      $display("FAIL nominal_rx got v=%b d=%h exp v=1 d=%h", bus.RVALID, bus.RDATA, exp_q[0]);
    end
    @(negedge clk);
    checks++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== exp_q[0]) begin
      failures++;
      $display("FAIL nominal_hold got v=%b d=%h exp v=1 d=%h", bus.RVALID, bus.RDATA, exp_q[0]);
    end
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (bus.RVALID !== 1'b0) begin
      failures++;
      $display("FAIL nominal_pop_rvalid got=%b exp=0", bus.RVALID);
    end
  endtask

  task automatic test_false_start();
    logic [7:0] e, d;
    bit ok;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (bus.RVALID !== 1'b0 || ferr !== 1'b0) begin
      failures++;
      $display("FAIL false_start got v=%b ferr=%b exp v=0 ferr=0", bus.RVALID, ferr);
    end
    send_frame(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(d, ok);
      checks++;
      if (!ok || d !== e) begin
        failures++;
        $display("FAIL false_start_next got=%h ok=%0d exp=%h", d, ok, e);
      end
    end
  endtask

  task automatic test_framing_error();
    logic [7:0] e, d;
    bit ok;
    send_frame(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (ferr !== 1'b1 || bus.RVALID !== 1'b0) begin
      failures++;
      $display("FAIL ferr_set got ferr=%b v=%b exp ferr=1 v=0", ferr, bus.RVALID);
    end
    send_frame(8'h12, 1'b1);
    exp_q.push_back(8'h12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(d, ok);
      checks++;
      if (!ok || d !== e) begin
        failures++;
        $display("FAIL ferr_next_frame got=%h ok=%0d exp=%h", d, ok, e);
      end
    end
    checks++;
    if (ferr !== 1'b1 || bus.RVALID !== 1'b0) begin
      failures++;
      $display("FAIL ferr_sticky got ferr=%b v=%b exp ferr=1 v=0", ferr, bus.RVALID);
    end
    pulse_clr();
    checks++;
    if (ferr !== 1'b0) begin
      failures++;
      $display("FAIL ferr_clear got=%b exp=0", ferr);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] e, d;
    bit ok;
    bit exp_ovr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (exp_q.size() < 4) exp_q.push_back(8'(i));
      else exp_ovr = 1'b1;
      checks++;
      if (overrun !== exp_ovr) begin
        failures++;
        $display("FAIL overrun_frame%0d got=%b exp=%b", i, overrun, exp_ovr);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(d, ok);
      checks++;
      if (!ok || d !== e) begin
        failures++;
        $display("FAIL overrun_drain got=%h ok=%0d exp=%h", d, ok, e);
      end
    end
    checks++;
    if (bus.RVALID !== 1'b0) begin
      failures++;
      $display("FAIL overrun_empty got=%b exp=0", bus.RVALID);
    end
    pulse_clr();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got=%b exp=0", overrun);
    end
  endtask

  task automatic test_full_pop_at_push();
    logic [7:0] e, d;
    bit ok;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1);
      exp_q.push_back(8'(i));
    end
    // Stop sample lands on the 155th rising edge after the start bit is driven.
    for (int k = 0; k < FRAME; k++) begin
      if (k % CPB == 0) rx = frame_bit(8'h99, 1'b1, k / CPB);
      if (k == 154) begin
        checks++;
        if (bus.RVALID !== 1'b1 || bus.RDATA !== exp_q[0]) begin
          failures++;
          $display("FAIL full_pop_head got v=%b d=%h exp v=1 d=%h", bus.RVALID, bus.RDATA, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(8'h99);
        bus.RREADY = 1'b1;
      end else begin
        bus.RREADY = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_overrun got=%b exp=0", overrun);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(d, ok);
      checks++;
      if (!ok || d !== e) begin
        failures++;
        $display("FAIL full_pop_drain got=%h ok=%0d exp=%h", d, ok, e);
      end
    end
    checks++;
    if (bus.RVALID !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_empty got=%b exp=0", bus.RVALID);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e, d;
    bit ok;
    send_frame(8'h7E, 1'b1);
    exp_q.push_back(8'h7E);
    for (int k = 0; k < FRAME; k++) begin
      if (k % CPB == 0) rx = frame_bit(8'hF0, 1'b1, k / CPB);
      if (k == 5 * CPB + 8) begin
        nrst = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({bus.RDATA, bus.RVALID, ferr, overrun} !== 11'h000) begin
          failures++;
          $display("FAIL midframe_reset got=%h exp=000", {bus.RDATA, bus.RVALID, ferr, overrun});
        end
      end
      if (k == 5 * CPB + 11) nrst = 1'b1;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (bus.RVALID !== 1'b0) begin
      failures++;
      $display("FAIL midframe_no_byte got=%b exp=0", bus.RVALID);
    end
    send_frame(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(d, ok);
      checks++;
      if (!ok || d !== e) begin
        failures++;
        $display("FAIL midframe_next got=%h ok=%0d exp=%h", d, ok, e);
      end
    end
  endtask

  initial begin
    clk        = 1'b0;
    nrst       = 1'b0;
    rx         = 1'b1;
    clr_err    = 1'b0;
    bus.RREADY = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_false_start();
    test_framing_error();
    test_overrun();
    test_full_pop_at_push();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that deserialises the MCU's RX_DSER pin into bytes. It is the receiving end of the 8N1 serial link driven by the transmitter that drives TX_DSER.
- Format is 8N1: 8 data bits LSB first, no parity, 1 stop bit, idle-high line, fixed baud set by parameter.
- Received bytes are buffered in a small first-word-fall-through FIFO and handed to the core-side data-memory glue through a valid/ready pop interface.
- Framing and overrun faults are reported as sticky flags.

Parameters:
- CLKS_PER_BIT, 868: CLK cycles per bit (100 MHz / 115200). Must be >= 4.
- FIFO_DEPTH, 4: receive FIFO entries. Must be a power of 2 and >= 2.

Ports:
- CLK  in  1  system clock.
- NRST  in  1  asynchronous active-low reset.
- RX_DSER  in  1  serial input, asynchronous to CLK, idle high.
- RDATA  out  8  head-of-FIFO byte. Valid while RVALID=1.
- RVALID  out  1  FIFO not empty.
- RREADY  in  1  pop request. A pop occurs on a cycle with RVALID&&RREADY.
- FERR  out  1  sticky framing error (stop bit sampled 0).
- OVERRUN  out  1  sticky overrun (byte dropped, FIFO full).
- CLR_ERR  in  1  synchronous clear of FERR and OVERRUN.

Behaviour:
- Reset and clock (already decided): one clock CLK; NRST is asynchronous, active-low.
- Reset values: RDATA=0, RVALID=0, FERR=0, OVERRUN=0. FIFO empty, FSM in IDLE, counters 0, synchroniser flops reset to 1.
- Reset asserted mid-frame aborts the frame. Nothing is pushed.
- Input synchroniser: RX_DSER passes through 2 flops to give rx_s. The FSM uses rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rx_s=0, load the bit counter with 0 and go to START.
- START: count CLKS_PER_BIT/2 cycles (integer division) to reach mid start bit, then sample.
  - rx_s=1: false start. Return to IDLE, no flag.
  - rx_s=0: clear the counter, bit index=0, go to DATA.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit index]. LSB is received first.
  - After bit index 7 is sampled, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s=1: push the byte (see FIFO rules), go to IDLE.
  - rx_s=0: set FERR, drop the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- Latency: RVALID rises on the cycle after the stop-bit sample, when the FIFO was empty.
- Next-frame timing: a start edge arriving in the cycle after the stop sample is detected normally. No dead time beyond IDLE re-entry.
- FIFO:
  - Circular buffer with rd/wr pointers of log2(FIFO_DEPTH)+1 bits. Wrap-around is natural.
  - RDATA = mem[rd_ptr]. The head byte is visible combinationally from storage, with no extra read latency.
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and OVERRUN is set. Existing FIFO contents are unchanged.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - A pop with RVALID=0 is ignored.
- Flags:
  - FERR and OVERRUN are set by their events and held until CLR_ERR=1 or reset.
  - If a set event and CLR_ERR occur in the same cycle, the flag ends the cycle set (set wins).
- Counters:
  - The bit-timing counter is sized $clog2(CLKS_PER_BIT) bits.
  - The counter never exceeds CLKS_PER_BIT-1.

Test Plan:
- Nominal byte: CLKS_PER_BIT=16. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop).
  - Required: RVALID=1 with RDATA=0xA5.
  - Required: RDATA=0xA5 stays after 1 idle cycle with RREADY=0, and RVALID drops the cycle after the RREADY pulse.
- False start: a 3-cycle low glitch on an idle line, CLKS_PER_BIT=16.
  - Required: RVALID stays 0 and FERR stays 0.
  - Required: a following 0x3C frame is received correctly.
- Framing error: send 0x55 with stop bit 0, held low for 2 extra bit times.
  - Required: FERR=1, no push, WAIT_IDLE until the line is high.
  - Required: the next frame 0x12 is received. CLR_ERR then returns FERR to 0.
- Overrun: FIFO_DEPTH=4, send 0x01..0x05 back-to-back with RREADY=0.
  - Required: OVERRUN=1 after the 5th stop bit.
  - Required: popping yields 0x01,0x02,0x03,0x04, then RVALID=0.
- Full with pop at push: with 4 entries held, assert RREADY in exactly the stop-sample cycle of a 5th byte 0x99.
  - Required: OVERRUN=0, and the pops continue 0x02,0x03,0x04,0x99.
- Reset mid-frame: assert NRST low during data bit 4 of 0xF0.
  - Required: all outputs 0 immediately (asynchronous), no byte after release.
  - Required: the next full frame 0x81 is received correctly.
